count_arbiter: RTL and testbench
================================

COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 The block SHALL have a single clock `clk` and a synchronous, active-high reset `reset`.
REQ-002 `clk`  input  1  rising-edge clock for all state.
REQ-003 `reset`  input  1  synchronous, active-high; sampled on the `clk` rising edge.
REQ-004 `req`  input  2  level request per requester (bit0 = R0, bit1 = R1).
REQ-005 `lim0`  input  4  terminal count for R0; sampled only at grant.
REQ-006 `lim1`  input  4  terminal count for R1; sampled only at grant.
REQ-007 `abort`  input  1  terminates the current run; honoured in RUN only.
REQ-008 `gnt`  output  2  one-hot grant; held for the whole run, including the DONE cycle.
REQ-009 `count`  output  4  shared up-counter value.
REQ-010 `busy`  output  1  high in RUN and DONE.
REQ-011 `done`  output  2  one-cycle completion pulse on the granted requester's bit.
REQ-012 `aborted`  output  1  one-cycle pulse when a run is aborted.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-014 In IDLE with `req` != 0, the block SHALL select a winner round-robin, latch its limit into `lim_q`, latch its id, set `count` to 0 and enter RUN on the next edge.
REQ-015 Round-robin: the requester served last SHALL have the lower priority; a single requester always wins.
REQ-016 In IDLE with `req` == 0, the state, `count` and the pointer SHALL hold; `gnt`, `done`, `aborted` and `busy` SHALL be 0.
REQ-017 In RUN with `abort` = 1, the block SHALL go to IDLE, pulse `aborted` for one cycle (the first IDLE cycle), clear `count` to 0 and leave the round-robin pointer unchanged.
REQ-018 In RUN with `abort` = 0 and `count` == `lim_q`, the block SHALL go to DONE with `count` holding `lim_q`.
REQ-019 In RUN otherwise, `count` SHALL increment by 1 per cycle; it never wraps, because 4'd15 is the maximum limit and is caught by REQ-018.
REQ-020 In DONE, `done[id]` SHALL be 1 for exactly that cycle; the next state SHALL be IDLE and the pointer SHALL record `id` as last served.
REQ-021 Latency: with a request sampled in IDLE at edge N and limit L, RUN runs edges N+1..N+1+L (`count` 0..L), DONE occurs at N+2+L and IDLE at N+3+L; run length is L+1 cycles.
REQ-022 L = 0 SHALL give exactly one RUN cycle with `count` = 0, then DONE.
REQ-023 Changes to `lim0`/`lim1` or deassertion of `req` during RUN/DONE SHALL be ignored; only `abort` ends a run early.
REQ-024 If `abort` and the terminal condition occur in the same RUN cycle, abort SHALL win: no `done`, `aborted` pulses.
REQ-025 `abort` in IDLE or DONE SHALL be ignored.
REQ-026 A requester still asserting `req` in the DONE cycle SHALL be re-arbitrated in the following IDLE cycle under round-robin.
REQ-027 `done` and `aborted` SHALL never be high in the same cycle, and at most one `done` bit SHALL be high in any cycle.

Reset
REQ-028 With `reset` = 1 at a rising edge, the next state SHALL be IDLE, `count` = 0, `gnt` = 0, `done` = 0, `aborted` = 0, `busy` = 0, `lim_q` = 0.
REQ-029 Reset SHALL set the pointer to "R1 served last", so R0 wins the first contention.
REQ-030 Reset SHALL override every other input in the same cycle, including mid-RUN and in the DONE cycle; no `done` or `aborted` pulse follows a reset.

Verification
REQ-031 Single run: reset, then `req` = 01, `lim0` = 3 -> `gnt` = 01 for 5 cycles, `count` 0,1,2,3,3, `done` = 01 on the 5th, then IDLE.
REQ-032 Contention: `req` = 11 held, `lim0` = 1, `lim1` = 2 -> grants alternate R0, R1, R0; each `done` on the correct bit; IDLE gap of 1 cycle between runs.
REQ-033 Abort: R1 granted, `lim1` = 15, `abort` at `count` = 5 -> next cycle `aborted` = 1, `count` = 0, `gnt` = 00; no `done`.
REQ-034 Boundaries: `lim0` = 0 -> 1 RUN cycle then `done`; `lim0` = 15 -> `count` reaches 15 with no wrap; abort coincident with `count` == `lim_q` -> `aborted` only.
REQ-035 Reset mid-operation: `reset` at `count` = 7 of a 15-run -> all outputs 0 next cycle; then `req` = 11 -> R0 granted first.

Source files
------------

// File: rtl/count_arbiter_if.sv
// Bundle of request/limit/abort inputs and grant/status outputs for count_arbiter.
interface count_arbiter_if;
  logic [1:0] req;
  logic [3:0] lim0;
  logic [3:0] lim1;
  logic       abort;
  logic [1:0] gnt;
  logic [3:0] count;
  logic       busy;
  logic [1:0] done;
  logic       aborted;

  modport slave (
    input  req, lim0, lim1, abort,
    output gnt, count, busy, done, aborted
  );

  modport master (
    output req, lim0, lim1, abort,
    input  gnt, count, busy, done, aborted
  );
endinterface

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter; the winner owns a shared up-counter that
// runs from 0 to its latched limit, then pulses done for one cycle.
module count_arbiter (
  input logic            clk,
  input logic            reset,
  count_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_stateNext;
  logic [3:0] r_count;
  logic [3:0] w_countNext;
  logic [3:0] r_limQ;
  logic [3:0] w_limQNext;
  logic       r_id;
  logic       w_idNext;
  logic       r_lastR1;
  logic       w_lastR1Next;
  logic       r_aborted;
  logic       w_abortedNext;
  logic       w_winner;

  // Pick the winner: a lone requester always wins, on contention the one not served last wins.
  always_comb begin
    w_winner = 1'b0;
    if (bus.req == 2'b10) begin
      w_winner = 1'b1;
    end else if (bus.req == 2'b11) begin
      w_winner = ~r_lastR1;
    end
  end

  // Next-state logic; run-time changes to req/limits are ignored, only abort ends a run early.
  always_comb begin
    w_stateNext   = r_state;
    w_countNext   = r_count;
    w_limQNext    = r_limQ;
    w_idNext      = r_id;
    w_lastR1Next  = r_lastR1;
    w_abortedNext = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          w_stateNext = RUN;
          w_idNext    = w_winner;
          w_limQNext  = w_winner ? bus.lim1 : bus.lim0;
          w_countNext = 4'd0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          w_stateNext   = IDLE;
          w_countNext   = 4'd0;
          w_abortedNext = 1'b1;
        end else if (r_count == r_limQ) begin
          w_stateNext = DONE;
        end else begin
          w_countNext = r_count + 4'd1;
        end
      end
      DONE: begin
        w_stateNext  = IDLE;
        w_lastR1Next = r_id;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State registers; reset leaves the pointer at "R1 served last" so R0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= 4'd0;
      r_limQ    <= 4'd0;
      r_id      <= 1'b0;
      r_lastR1  <= 1'b1;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_count   <= w_countNext;
      r_limQ    <= w_limQNext;
      r_id      <= w_idNext;
      r_lastR1  <= w_lastR1Next;
      r_aborted <= w_abortedNext;
    end
  end

  // Outputs decoded purely from registered state.
  assign bus.gnt     = (r_state != IDLE) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = (r_state == DONE) ? (r_id ? 2'b10 : 2'b01) : 2'b00;
  assign bus.count   = r_count;
  assign bus.aborted = r_aborted;

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: directed scenarios plus random traffic,
// all compared against a run-length reference model.
module tb_count_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  count_arbiter_if bus ();

  count_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: a run is "elapsed" cycles old; RUN while elapsed <= lim, DONE at lim+1.
  bit mActive;
  bit mWho;
  bit mLast;
  bit mAbort;
  int mLim;
  int mElapsed;
  int mCount;

  task automatic modelStep();
    if (reset) begin
      mActive = 0; mLast = 1; mAbort = 0; mCount = 0; mWho = 0; mLim = 0; mElapsed = 0;
    end else if (!mActive) begin
      mAbort = 0;
      if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) mWho = mLast ? 1'b0 : 1'b1;
        else                  mWho = bus.req[1];
        mLim     = mWho ? int'(bus.lim1) : int'(bus.lim0);
        mActive  = 1;
        mElapsed = 0;
        mCount   = 0;
      end
    end else if (mElapsed <= mLim) begin
      mAbort = 0;
      if (bus.abort) begin
        mActive = 0; mAbort = 1; mCount = 0;
      end else begin
        mElapsed = mElapsed + 1;
        mCount   = (mElapsed > mLim) ? mLim : mElapsed;
      end
    end else begin
      mAbort  = 0;
      mActive = 0;
      mLast   = mWho;
    end
  endtask

  // Packed {gnt, count, busy, done, aborted}.
  function automatic logic [9:0] expVec();
    logic [1:0] g;
    logic [1:0] d;
    g = mActive ? (2'b01 << mWho) : 2'b00;
    d = (mActive && mElapsed == mLim + 1) ? (2'b01 << mWho) : 2'b00;
    return {g, 4'(mCount), mActive, d, mAbort};
  endfunction

  function automatic logic [9:0] dutVec();
    return {bus.gnt, bus.count, bus.busy, bus.done, bus.aborted};
  endfunction

  // One clock: DUT and model both consume the inputs at the rising edge; outputs read at falling edge.
  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1; bus.req = 0; bus.abort = 0;
    cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; bus.req = 2'b11; bus.abort = 1; bus.lim0 = 4'd9; bus.lim1 = 4'd4;
    cycle();
    checks++;
    if (dutVec() !== 10'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", dutVec(), 10'd0);
    end
    reset = 0; bus.req = 0; bus.abort = 0;
    cycle();
    checks++;
    if (dutVec() !== expVec()) begin
      errors++; $display("[TB] FAIL reset_idle: got %b expected %b", dutVec(), expVec());
    end
  endtask

  task automatic test_single_run();
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
    doReset();
    bus.req = 2'b01; bus.lim0 = 4'd3; bus.lim1 = 4'd7;
    cycle();
    bus.req = 2'b00; bus.lim0 = 4'd12;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.gnt !== 2'b01 || bus.count !== seq[i] || bus.done !== ((i == 4) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("[TB] FAIL single_run cyc %0d: got gnt=%b count=%0d done=%b expected gnt=01 count=%0d done=%b",
                 i, bus.gnt, bus.count, bus.done, seq[i], (i == 4) ? 2'b01 : 2'b00);
      end
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("[TB] FAIL single_run_model cyc %0d: got %b expected %b", i, dutVec(), expVec());
      end
      cycle();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
      errors++; $display("[TB] FAIL single_run_idle: got busy=%b gnt=%b expected busy=0 gnt=00", bus.busy, bus.gnt);
    end
  endtask

  task automatic test_contention();
    logic [1:0] order [$];
    logic [1:0] prevGnt;
    doReset();
    bus.req = 2'b11; bus.lim0 = 4'd1; bus.lim1 = 4'd2;
    prevGnt = 2'b00;
    for (int i = 0; i < 15; i++) begin
      cycle();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("[TB] FAIL contention_model cyc %0d: got %b expected %b", i, dutVec(), expVec());
      end
      if (bus.gnt != 2'b00 && prevGnt == 2'b00) order.push_back(bus.gnt);
      prevGnt = bus.gnt;
    end
    bus.req = 2'b00;
    checks++;
    if (order.size() < 3 || order[0] !== 2'b01 || order[1] !== 2'b10 || order[2] !== 2'b01) begin
      errors++;
      $display("[TB] FAIL contention_order: got %0d grants first=%b expected 01,10,01",
               order.size(), (order.size() > 0) ? order[0] : 2'bxx);
    end
  endtask

  task automatic test_abort();
    doReset();
    bus.req = 2'b10; bus.lim1 = 4'd15; bus.lim0 = 4'd2;
    cycle();
    bus.req = 2'b00;
    for (int i = 0; i < 5; i++) cycle();
    checks++;
    if (bus.count !== 4'd5 || bus.gnt !== 2'b10) begin
      errors++; $display("[TB] FAIL abort_pre: got count=%0d gnt=%b expected count=5 gnt=10", bus.count, bus.gnt);
    end
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    checks++;
    if (dutVec() !== 10'b00_0000_0_00_1) begin
      errors++; $display("[TB] FAIL abort_pulse: got %b expected %b", dutVec(), 10'b00_0000_0_00_1);
    end
    // Pointer untouched by abort: R0 still wins the next contention.
    bus.req = 2'b11; bus.lim0 = 4'd0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("[TB] FAIL abort_after cyc %0d: got %b expected %b", i, dutVec(), expVec());
      end
    end
    bus.req = 2'b00;
  endtask

  task automatic test_boundaries();
    logic sawDone;
    int   maxCount;
    doReset();
    bus.req = 2'b01; bus.lim0 = 4'd0;
    cycle();
    bus.req = 2'b00;
    checks++;
    if (dutVec() !== 10'b01_0000_1_00_0) begin
      errors++; $display("[TB] FAIL lim0_zero_run: got %b expected %b", dutVec(), 10'b01_0000_1_00_0);
    end
    cycle();
    checks++;
    if (dutVec() !== 10'b01_0000_1_01_0) begin
      errors++; $display("[TB] FAIL lim0_zero_done: got %b expected %b", dutVec(), 10'b01_0000_1_01_0);
    end
    cycle();
    bus.req = 2'b01; bus.lim0 = 4'd15;
    sawDone = 0; maxCount = 0;
    for (int i = 0; i < 19; i++) begin
      cycle();
      bus.req = 2'b00;
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("[TB] FAIL lim15_model cyc %0d: got %b expected %b", i, dutVec(), expVec());
      end
      if (bus.busy && int'(bus.count) > maxCount) maxCount = int'(bus.count);
      if (bus.done == 2'b01) sawDone = 1;
    end
    checks++;
    if (maxCount != 15 || !sawDone) begin
      errors++; $display("[TB] FAIL lim15_reach: got max=%0d done=%0d expected max=15 done=1", maxCount, sawDone);
    end
    bus.req = 2'b01; bus.lim0 = 4'd2;
    cycle();
    bus.req = 2'b00;
    cycle();
    cycle();
    bus.abort = 1;
    cycle();
    bus.abort = 0;
    checks++;
    if (dutVec() !== 10'b00_0000_0_00_1) begin
      errors++; $display("[TB] FAIL abort_at_limit: got %b expected %b", dutVec(), 10'b00_0000_0_00_1);
    end
    cycle();
    checks++;
    if (dutVec() !== expVec()) begin
      errors++; $display("[TB] FAIL abort_at_limit_after: got %b expected %b", dutVec(), expVec());
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    bus.req = 2'b01; bus.lim0 = 4'd15;
    cycle();
    bus.req = 2'b00;
    for (int i = 0; i < 7; i++) cycle();
    checks++;
    if (bus.count !== 4'd7) begin
      errors++; $display("[TB] FAIL reset_mid_pre: got count=%0d expected 7", bus.count);
    end
    reset = 1; bus.abort = 1;
    cycle();
    reset = 0; bus.abort = 0;
    checks++;
    if (dutVec() !== 10'd0) begin
      errors++; $display("[TB] FAIL reset_mid_clear: got %b expected %b", dutVec(), 10'd0);
    end
    bus.req = 2'b11; bus.lim0 = 4'd1; bus.lim1 = 4'd1;
    cycle();
    bus.req = 2'b00;
    checks++;
    if (bus.gnt !== 2'b01) begin
      errors++; $display("[TB] FAIL reset_mid_first: got gnt=%b expected 01", bus.gnt);
    end
  endtask

  task automatic test_random();
    doReset();
    for (int i = 0; i < 600; i++) begin
      bus.req   = 2'($urandom_range(0, 3));
      bus.lim0  = 4'($urandom_range(0, 15));
      bus.lim1  = 4'($urandom_range(0, 15));
      bus.abort = ($urandom_range(0, 9) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      cycle();
      checks++;
      if (dutVec() !== expVec()) begin
        errors++; $display("[TB] FAIL random cyc %0d: got %b expected %b", i, dutVec(), expVec());
      end
    end
    reset = 0; bus.req = 0; bus.abort = 0;
  endtask

  // Scenario sequence.
  initial begin
    clk = 0; reset = 1; checks = 0; errors = 0;
    bus.req = 0; bus.lim0 = 0; bus.lim1 = 0; bus.abort = 0;
    mActive = 0; mWho = 0; mLast = 1; mAbort = 0; mLim = 0; mElapsed = 0; mCount = 0;
    test_reset();
    test_single_run();
    test_contention();
    test_abort();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
